// File: rtl/alu_result_fifo_if.sv
// Valid/ready bundle between the ALU result producer, the result buffer and its consumer.
interface alu_result_fifo_if;
  logic       in_valid;
  logic [3:0] in_alu;
  logic       in_carry;
  logic       in_zero;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_alu;
  logic       out_carry;
  logic       out_zero;

  modport master (
    output in_valid, in_alu, in_carry, in_zero, out_ready,
    input  out_valid, out_alu, out_carry, out_zero
  );

  modport slave (
    input  in_valid, in_alu, in_carry, in_zero, out_ready,
    output out_valid, out_alu, out_carry, out_zero
  );
endinterface

// File: rtl/alu_result_fifo.sv
// First-word-fall-through buffer for ALU results; drops, flags and counts results that arrive while full.
module alu_result_fifo #(
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  alu_result_fifo_if.slave    bus,
  output logic [AW:0]         count,
  output logic                full,
  output logic                empty,
  output logic                overflow,
  output logic [7:0]          drop_cnt,
  input  logic                clr_ovf
);

  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = 6;

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  logic          drop;

  assign full          = (count == CW'(DEPTH));
  assign empty         = (count == '0);
  assign bus.out_valid = !empty;

  // A pop on a full buffer frees the slot the same cycle, so the push still lands.
  assign pop  = bus.out_valid && bus.out_ready;
  assign push = bus.in_valid && (!full || pop);
  assign drop = bus.in_valid && full && !pop;

  assign {bus.out_alu, bus.out_carry, bus.out_zero} = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[wr_ptr] <= {bus.in_alu, bus.in_carry, bus.in_zero};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // A drop in the same cycle as a clear takes precedence over the clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (clr_ovf)                drop_cnt <= 8'd1;
      else if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_alu_result_fifo.sv
// Scoreboard bench for alu_result_fifo: directed scenarios plus a randomized stream.
module tb_alu_result_fifo;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       clr_ovf;
  logic [3:0] count;
  logic       full;
  logic       empty;
  logic       overflow;
  logic [7:0] drop_cnt;

  alu_result_fifo_if bus ();

  alu_result_fifo #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus.slave),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .overflow (overflow),
    .drop_cnt (drop_cnt),
    .clr_ovf  (clr_ovf)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int model_cnt = 0;
  int exp_ovf = 0;
  int exp_drop = 0;
  int push_total = 0;
  logic [5:0] sbq [$];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every accepted head against the oldest expected entry.
  always @(negedge clk) begin
    int exp_head;
    chk("out_valid", int'(bus.out_valid), int'(sbq.size() != 0));
    if (bus.out_valid && bus.out_ready) begin
      exp_head = (sbq.size() != 0) ? int'(sbq.pop_front()) : -1;
      chk("head", int'({bus.out_alu, bus.out_carry, bus.out_zero}), exp_head);
    end
  end

  // One clock of stimulus; the reference model decides acceptance from its own occupancy.
  task automatic cycle(input logic v, input logic [3:0] a, input logic c, input logic z,
                       input logic rdy, input logic clr);
    bit pop_e, acc, drp;
    bus.in_valid  = v;
    bus.in_alu    = a;
    bus.in_carry  = c;
    bus.in_zero   = z;
    bus.out_ready = rdy;
    clr_ovf       = clr;
    pop_e = (model_cnt > 0) && rdy;
    acc   = v && ((model_cnt < DEPTH) || pop_e);
    drp   = v && !acc;
    @(posedge clk);
    if (pop_e) model_cnt--;
    if (acc) begin
      model_cnt++;
      push_total++;
      sbq.push_back({a, c, z});
    end
    if (drp) begin
      exp_ovf  = 1;
      exp_drop = clr ? 1 : ((exp_drop < 255) ? exp_drop + 1 : 255);
    end else if (clr) begin
      exp_ovf  = 0;
      exp_drop = 0;
    end
    #1;
    chk("count", int'(count), model_cnt);
    chk("full", int'(full), int'(model_cnt == DEPTH));
    chk("empty", int'(empty), int'(model_cnt == 0));
    chk("overflow", int'(overflow), exp_ovf);
    chk("drop_cnt", int'(drop_cnt), exp_drop);
  endtask

  task automatic idle_in();
    bus.in_valid  = 1'b0;
    bus.in_alu    = '0;
    bus.in_carry  = 1'b0;
    bus.in_zero   = 1'b0;
    bus.out_ready = 1'b0;
    clr_ovf       = 1'b0;
  endtask

  task automatic drain();
    for (int g = 0; g < 4 * DEPTH && model_cnt > 0; g++) cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("drained", int'(empty), 1);
  endtask

  task automatic fill_seq();
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 4'(i), 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    idle_in();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_word", int'({bus.out_alu, bus.out_carry, bus.out_zero}), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_drop_cnt", int'(drop_cnt), 0);

    // Basic order
    cycle(1'b1, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("order_count", int'(count), 3);
    chk("order_head", int'(bus.out_alu), 3);
    repeat (3) cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("order_empty", int'(empty), 1);
    chk("order_out_valid", int'(bus.out_valid), 0);

    // Fill and drop
    for (int i = 0; i < 10; i++) cycle(1'b1, 4'(i), 1'b0, 1'b0, 1'b0, 1'b0);
    chk("fill_full", int'(full), 1);
    chk("fill_count", int'(count), 8);
    chk("fill_overflow", int'(overflow), 1);
    chk("fill_drop_cnt", int'(drop_cnt), 2);
    drain();
    cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Push and pop together while full
    fill_seq();
    cycle(1'b1, 4'hA, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("pp_count", int'(count), 8);
    chk("pp_no_drop", int'(drop_cnt), 0);
    drain();

    // Clear versus drop
    fill_seq();
    repeat (3) cycle(1'b1, 4'h5, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("cd_drop3", int'(drop_cnt), 3);
    cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("cd_clr_ovf", int'(overflow), 0);
    chk("cd_clr_cnt", int'(drop_cnt), 0);
    cycle(1'b1, 4'h6, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("cd_win_ovf", int'(overflow), 1);
    chk("cd_win_cnt", int'(drop_cnt), 1);
    drain();
    cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Random stream until 1000 results have been accepted
    begin
      int start = push_total;
      for (int n = 0; n < 8000 && (push_total - start) < 1000; n++) begin
        cycle(1'($urandom_range(0, 99) < 85), 4'($urandom), 1'($urandom), 1'($urandom),
              1'($urandom_range(0, 99) < 70), 1'($urandom_range(0, 99) < 3));
      end
    end
    drain();
    cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Drop counter saturation
    fill_seq();
    for (int i = 0; i < 300; i++) cycle(1'b1, 4'(i), 1'b0, 1'b0, 1'b0, 1'b0);
    chk("sat_drop_cnt", int'(drop_cnt), 255);
    drain();
    cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Mid-operation reset
    for (int i = 0; i < 5; i++) cycle(1'b1, 4'(i + 9), 1'b1, 1'b0, 1'b0, 1'b0);
    chk("mr_count5", int'(count), 5);
    #1;
    reset = 1'b0;
    sbq.delete();
    model_cnt = 0;
    exp_ovf   = 0;
    exp_drop  = 0;
    #1;
    chk("mr_out_valid", int'(bus.out_valid), 0);
    chk("mr_count", int'(count), 0);
    chk("mr_empty", int'(empty), 1);
    idle_in();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    cycle(1'b1, 4'hC, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("mr_after_word", int'({bus.out_alu, bus.out_carry, bus.out_zero}), int'({4'hC, 1'b0, 1'b1}));
    drain();

    idle_in();
    repeat (2) @(posedge clk);
    chk("sb_empty_end", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/alu_result_fifo.md
# alu_result_fifo

Result buffer that sits directly downstream of the 4-bit ALU. It captures every `{alu, carry, zero}` result the ALU flags with `valid_out` into a DEPTH-entry FIFO. It presents results to the consumer through a first-word-fall-through valid/ready handshake. The ALU has no backpressure, so results arriving while the buffer is full are dropped, flagged and counted.

## Interface
- DEPTH, 8: number of entries; must be a power of two, ≥ 2.
- AW, $clog2(DEPTH): pointer width; derived, not to be overridden.
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  ALU `valid_out`; a result is offered this cycle.
- in_alu  in  4  ALU result.
- in_carry  in  1  ALU carry flag.
- in_zero  in  1  ALU zero flag.
- out_valid  out  1  head entry available (= !empty).
- out_ready  in  1  consumer accepts head entry this cycle.
- out_alu  out  4  head entry result.
- out_carry  out  1  head entry carry.
- out_zero  out  1  head entry zero.
- count  out  AW+1  number of stored entries, 0..DEPTH.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- overflow  out  1  sticky: at least one result dropped since last clear.
- drop_cnt  out  8  dropped results, saturating at 255.
- clr_ovf  in  1  synchronous clear of overflow and drop_cnt.

## Operation
- Entry format: 6 bits `{alu[3:0], carry, zero}`, stored unmodified.
- pop = out_valid && out_ready. When out_valid = 0, out_ready is ignored.
- push = in_valid && (!full || pop). When full, a simultaneous pop frees the slot in the same cycle, so the push is accepted.
- drop = in_valid && full && !pop. The result is discarded and no pointer or count changes.
- Write pointer and read pointer are each AW bits and wrap modulo DEPTH. count is maintained explicitly: +1 on push only, −1 on pop only, unchanged on both or neither.
- out_alu, out_carry and out_zero come combinationally from mem[rd_ptr]. When empty they show the stale contents of that slot, or 0 after reset. Consumers must qualify them with out_valid.
- On drop: overflow ← 1 and drop_cnt ← min(drop_cnt+1, 255).
- On clr_ovf: overflow ← 0 and drop_cnt ← 0. If clr_ovf and drop occur in the same cycle, the drop wins: overflow = 1 and drop_cnt = 1.
- There is no bypass. A push into an empty FIFO becomes visible the cycle after the write edge.
- Reset (any time, including mid-transfer): the FIFO becomes empty immediately. Held data is discarded.

## Timing
- Reset values, applied asynchronously while reset = 0:
  - pointers 0, count 0, full 0, empty 1;
  - out_valid 0, out_alu 0, out_carry 0, out_zero 0 (memory cleared);
  - overflow 0, drop_cnt 0.
- Release of reset is synchronous to clk. The first capture happens at the first rising edge with reset = 1.
- Push latency: a result sampled at edge N appears on out_* with out_valid = 1 during cycle N+1, if the FIFO was empty.
- Pop: the head is consumed at the edge where out_valid && out_ready. The next entry is presented in the following cycle with no bubble, so one pop per cycle is sustainable.
- Throughput: one push and one pop per cycle. A full FIFO with continuous pop and push stays full with no drops.
- full, empty and count are registered-state derived and reflect the state after the last edge. overflow and drop_cnt update at the edge where the drop occurs.

## Test plan
- Reset and basic order: pulse reset low, then push results 0x3/c0/z0, 0x0/c1/z1 and 0xF/c0/z0 on consecutive cycles with out_ready = 0. Expect count = 3 and out_alu = 0x3. Then set out_ready = 1 and expect the outputs 0x3, 0x0, 0xF in order, after which empty = 1 and out_valid = 0.
- Fill and drop: with out_ready = 0, push 10 results with alu = 0..9 (DEPTH 8). Expect full = 1, count = 8, overflow = 1 and drop_cnt = 2. Then drain and expect exactly alu 0..7.
- Simultaneous push and pop when full: fill with 0..7, then push 0xA with out_ready = 1 in the same cycle. Expect no drop, count to stay 8 and the pop to return 0. After draining, 0xA is the last entry out.
- Clear versus drop: with the FIFO full and drop_cnt = 3, assert clr_ovf alone and expect overflow = 0 and drop_cnt = 0. Then assert clr_ovf together with a dropping push and expect overflow = 1 and drop_cnt = 1.
- Wrap and saturation:
  - Stream 1000 random ALU results with random out_ready (≈70% asserted) and compare against a scoreboard queue. Expect zero mismatches and pointer wrap exercised more than 100 times.
  - Separately, with out_ready = 0 from full, push 300 results and expect drop_cnt = 255.
- Mid-operation reset: with count = 5, assert reset low mid-cycle. Expect out_valid = 0, count = 0 and empty = 1 immediately, without waiting for a clock edge. After release, the next push reads back correctly.
